mcpu_soc_memarb: RTL and testbench

Arbiter and sequencer that shares the single data port of the on-chip RAM and the MMIO block between the core's two data-memory request ports (mem2dc port 0 and port 1).
- Grants one request at a time (round-robin) and registers the address, data and byte enables.
- Routes each access to RAM (paddr[29]=0) or MMIO (paddr[29]=1) and waits the region's latency.
- Returns read data with a one-cycle done pulse to the granted port.
- Replaces the ad-hoc fixed-priority mux and address-compare done generation in the SoC top.

---
 rtl/mcpu_soc_pkg.sv | 17 +
 rtl/mcpu_soc_memarb_if.sv | 42 ++++
 rtl/mcpu_soc_rr_arb2.sv | 38 +++
 rtl/mcpu_soc_memarb.sv | 213 +++++++++++++++++++++
 tb/tb_mcpu_soc_memarb.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_soc_pkg.sv
// Shared types and constants for the SoC data-memory arbiter.
//   arb_state_e  : sequencer state encoding (IDLE/ISSUE/WAIT/RESP)
//   MMIO_SEL_BIT : word-address bit that selects MMIO over RAM
//   LAT_CNT_W    : width of the access latency down-counter
package mcpu_soc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   localparam int MMIO_SEL_BIT = 29;
   localparam int LAT_CNT_W    = 3;

endpackage

// File: rtl/mcpu_soc_memarb_if.sv
// Core-side data-memory request bus, two ports (0 and 1).
//   mem2dc_paddr0/1    : word address
//   mem2dc_write0/1    : byte write enables, 0 means read
//   mem2dc_valid0/1    : request, fields held stable until done
//   mem2dc_data_out0/1 : write data
//   mem2dc_done0/1     : one-cycle completion pulse
//   mem2dc_data_in0/1  : read data, valid while done is high
// master = core side, slave = arbiter side.
interface mcpu_soc_memarb_if;

   logic [29:0] mem2dc_paddr0;
   logic [29:0] mem2dc_paddr1;
   logic [3:0]  mem2dc_write0;
   logic [3:0]  mem2dc_write1;
   logic        mem2dc_valid0;
   logic        mem2dc_valid1;
   logic [31:0] mem2dc_data_out0;
   logic [31:0] mem2dc_data_out1;
   logic        mem2dc_done0;
   logic        mem2dc_done1;
   logic [31:0] mem2dc_data_in0;
   logic [31:0] mem2dc_data_in1;

   modport master (
      output mem2dc_paddr0, mem2dc_paddr1,
      output mem2dc_write0, mem2dc_write1,
      output mem2dc_valid0, mem2dc_valid1,
      output mem2dc_data_out0, mem2dc_data_out1,
      input  mem2dc_done0, mem2dc_done1,
      input  mem2dc_data_in0, mem2dc_data_in1
   );

   modport slave (
      input  mem2dc_paddr0, mem2dc_paddr1,
      input  mem2dc_write0, mem2dc_write1,
      input  mem2dc_valid0, mem2dc_valid1,
      input  mem2dc_data_out0, mem2dc_data_out1,
      output mem2dc_done0, mem2dc_done1,
      output mem2dc_data_in0, mem2dc_data_in1
   );

endinterface

// File: rtl/mcpu_soc_rr_arb2.sv
// Two-way round-robin picker.
//   clk_sys, rst_b : clock, async active-low reset
//   req            : request vector {port1, port0}
//   upd_en         : record upd_idx as the last granted port
//   upd_idx        : port that was just served
//   gnt_vld        : at least one request present
//   gnt_idx        : chosen port (combinational from req and last grant)
// Last grant resets to 1 so port 0 wins the first tie.
module mcpu_soc_rr_arb2 (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic [1:0] req,
   input  logic       upd_en,
   input  logic       upd_idx,
   output logic       gnt_vld,
   output logic       gnt_idx
);

   logic last_q;
   logic last_d;

   always_comb begin
      last_d = last_q;
      if (upd_en) last_d = upd_idx;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) last_q <= 1'b1;
      else        last_q <= last_d;
   end

   always_comb begin
      gnt_vld = |req;
      if (req[0] && req[1]) gnt_idx = ~last_q;
      else                  gnt_idx = req[1];
   end

endmodule

// File: rtl/mcpu_soc_memarb.sv
// Arbiter/sequencer sharing the RAM data port and the MMIO block between
// the two core data-memory ports.
//   clkrst_core_clk, clkrst_core_rst_n : clock, async active-low reset
//   mem2dc                             : two-port core request bus (slave)
//   ram_addr/wdata/byteen/wren/clken   : RAM port, strobes only in ISSUE
//   ram_q                              : RAM read data
//   mmio_addr/wdata/wren/rden          : MMIO port, strobes only in ISSUE
//   mmio_q                             : MMIO read data
//   arb_busy                           : state is not IDLE
//
// state | meaning
// IDLE  | no transaction; pick a requester and latch its fields
// ISSUE | strobes out for one cycle, latency counter loaded
// WAIT  | count down; capture read data when the counter hits 1
// RESP  | done pulse to granted port; chain the other port if it waits
module mcpu_soc_memarb
   import mcpu_soc_pkg::*;
#(
   parameter int RAM_AW   = 14,
   parameter int RAM_LAT  = 1,
   parameter int MMIO_LAT = 1
) (
   input  logic              clkrst_core_clk,
   input  logic              clkrst_core_rst_n,
   mcpu_soc_memarb_if.slave  mem2dc,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_byteen,
   output logic              ram_wren,
   output logic              ram_clken,
   input  logic [31:0]       ram_q,
   output logic [28:0]       mmio_addr,
   output logic [31:0]       mmio_wdata,
   output logic [3:0]        mmio_wren,
   output logic              mmio_rden,
   input  logic [31:0]       mmio_q,
   output logic              arb_busy
);

   arb_state_e           state_q, state_d;
   logic                 sel_q, sel_d;
   logic [28:0]          addr_q, addr_d;
   logic [3:0]           be_q, be_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 mmio_sel_q, mmio_sel_d;
   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]          resp_q, resp_d;
   logic                 done0_q, done0_d;
   logic                 done1_q, done1_d;
   logic                 ram_clken_q, ram_clken_d;
   logic                 ram_wren_q, ram_wren_d;
   logic [3:0]           mmio_wren_q, mmio_wren_d;
   logic                 mmio_rden_q, mmio_rden_d;

   logic [1:0]  req_vld;
   logic [29:0] req_paddr [2];
   logic [3:0]  req_be    [2];
   logic [31:0] req_wdata [2];

   logic gnt_vld;
   logic gnt_idx;
   logic upd_en;
   logic load;
   logic load_idx;

   always_comb begin
      req_vld      = {mem2dc.mem2dc_valid1, mem2dc.mem2dc_valid0};
      req_paddr[0] = mem2dc.mem2dc_paddr0;
      req_paddr[1] = mem2dc.mem2dc_paddr1;
      req_be[0]    = mem2dc.mem2dc_write0;
      req_be[1]    = mem2dc.mem2dc_write1;
      req_wdata[0] = mem2dc.mem2dc_data_out0;
      req_wdata[1] = mem2dc.mem2dc_data_out1;
   end

   mcpu_soc_rr_arb2 u_rr (
      .clk_sys (clkrst_core_clk),
      .rst_b   (clkrst_core_rst_n),
      .req     (req_vld),
      .upd_en  (upd_en),
      .upd_idx (sel_q),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      mmio_sel_d  = mmio_sel_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      ram_clken_d = 1'b0;
      ram_wren_d  = 1'b0;
      mmio_wren_d = 4'b0000;
      mmio_rden_d = 1'b0;
      upd_en      = 1'b0;
      load        = 1'b0;
      load_idx    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               load     = 1'b1;
               load_idx = gnt_idx;
            end
         end
         ST_ISSUE: begin
            // A withdrawn request aborts; anything already strobed stands.
            if (!req_vld[sel_q]) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = mmio_sel_q ? LAT_CNT_W'(MMIO_LAT) : LAT_CNT_W'(RAM_LAT);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (!req_vld[sel_q]) begin
               state_d = ST_IDLE;
            end else if (cnt_q == LAT_CNT_W'(1)) begin
               resp_d  = mmio_sel_q ? mmio_q : ram_q;
               done0_d = ~sel_q;
               done1_d = sel_q;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            // The served port's valid here is its old request; only the
            // other port can chain straight into a new ISSUE.
            upd_en = 1'b1;
            if (req_vld[~sel_q]) begin
               load     = 1'b1;
               load_idx = ~sel_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d    = ST_ISSUE;
         sel_d      = load_idx;
         addr_d     = req_paddr[load_idx][28:0];
         be_d       = req_be[load_idx];
         wdata_d    = req_wdata[load_idx];
         mmio_sel_d = req_paddr[load_idx][MMIO_SEL_BIT];
         if (req_paddr[load_idx][MMIO_SEL_BIT]) begin
            mmio_wren_d = req_be[load_idx];
            mmio_rden_d = ~|req_be[load_idx];
         end else begin
            ram_clken_d = 1'b1;
            ram_wren_d  = |req_be[load_idx];
         end
      end
   end

   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         mmio_sel_q  <= 1'b0;
         cnt_q       <= '0;
         resp_q      <= '0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         ram_clken_q <= 1'b0;
         ram_wren_q  <= 1'b0;
         mmio_wren_q <= 4'b0000;
         mmio_rden_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         mmio_sel_q  <= mmio_sel_d;
         cnt_q       <= cnt_d;
         resp_q      <= resp_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         ram_clken_q <= ram_clken_d;
         ram_wren_q  <= ram_wren_d;
         mmio_wren_q <= mmio_wren_d;
         mmio_rden_q <= mmio_rden_d;
      end
   end

   assign ram_addr   = addr_q[RAM_AW-1:0];
   assign ram_wdata  = wdata_q;
   assign ram_byteen = be_q;
   assign ram_wren   = ram_wren_q;
   assign ram_clken  = ram_clken_q;
   assign mmio_addr  = addr_q;
   assign mmio_wdata = wdata_q;
   assign mmio_wren  = mmio_wren_q;
   assign mmio_rden  = mmio_rden_q;
   assign arb_busy   = (state_q != ST_IDLE);

   assign mem2dc.mem2dc_done0    = done0_q;
   assign mem2dc.mem2dc_done1    = done1_q;
   assign mem2dc.mem2dc_data_in0 = resp_q;
   assign mem2dc.mem2dc_data_in1 = resp_q;

endmodule

// File: tb/tb_mcpu_soc_memarb.sv
// Directed bench for mcpu_soc_memarb with a 1-cycle RAM model and a
// 3-cycle MMIO model that only presents valid data in its capture cycle.
module tb_mcpu_soc_memarb;

   logic        clk;
   logic        rst_n;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_byteen;
   logic        ram_wren;
   logic        ram_clken;
   logic [31:0] ram_q;
   logic [28:0] mmio_addr;
   logic [31:0] mmio_wdata;
   logic [3:0]  mmio_wren;
   logic        mmio_rden;
   logic [31:0] mmio_q;
   logic        arb_busy;

   int total = 0;
   int bad   = 0;

   int n_clken = 0, n_wren = 0, n_rden = 0, n_done0 = 0, n_done1 = 0;

   mcpu_soc_memarb_if bus ();

   mcpu_soc_memarb #(.RAM_AW(14), .RAM_LAT(1), .MMIO_LAT(3)) dut (
      .clkrst_core_clk   (clk),
      .clkrst_core_rst_n (rst_n),
      .mem2dc            (bus),
      .ram_addr          (ram_addr),
      .ram_wdata         (ram_wdata),
      .ram_byteen        (ram_byteen),
      .ram_wren          (ram_wren),
      .ram_clken         (ram_clken),
      .ram_q             (ram_q),
      .mmio_addr         (mmio_addr),
      .mmio_wdata        (mmio_wdata),
      .mmio_wren         (mmio_wren),
      .mmio_rden         (mmio_rden),
      .mmio_q            (mmio_q),
      .arb_busy          (arb_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: synchronous read, byte-masked write, one cycle latency.
   logic [31:0] mem [0:16383];
   always @(posedge clk) begin
      if (ram_clken) begin
         ram_q <= mem[ram_addr];
         if (ram_wren)
            for (int b = 0; b < 4; b++)
               if (ram_byteen[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
   end

   // MMIO model: data is valid only in the third cycle after the read strobe.
   logic [2:0] mmio_pipe;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mmio_pipe <= 3'b000;
      else        mmio_pipe <= {mmio_pipe[1:0], mmio_rden};
   end
   assign mmio_q = mmio_pipe[2] ? 32'hCAFE_0001 : 32'hBAD0_BAD0;

   always @(negedge clk) begin
      if (ram_clken)        n_clken++;
      if (ram_wren)         n_wren++;
      if (mmio_rden)        n_rden++;
      if (bus.mem2dc_done0) n_done0++;
      if (bus.mem2dc_done1) n_done1++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_bus();
      bus.mem2dc_paddr0 = '0;    bus.mem2dc_paddr1 = '0;
      bus.mem2dc_write0 = '0;    bus.mem2dc_write1 = '0;
      bus.mem2dc_valid0 = 1'b0;  bus.mem2dc_valid1 = 1'b0;
      bus.mem2dc_data_out0 = '0; bus.mem2dc_data_out1 = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_bus();
      tick(); tick();
      total++;
      if ({arb_busy, bus.mem2dc_done0, bus.mem2dc_done1, ram_clken, ram_wren, mmio_rden, mmio_wren, ram_byteen} !== 12'h000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0", {arb_busy, bus.mem2dc_done0, bus.mem2dc_done1, ram_clken, ram_wren, mmio_rden, mmio_wren, ram_byteen});
      end
      total++;
      if ({ram_addr, mmio_addr, ram_wdata, bus.mem2dc_data_in0, bus.mem2dc_data_in1} !== '0) begin
         bad++; $display("FAIL reset_data: addr=%h mmio=%h wd=%h di0=%h di1=%h want 0", ram_addr, mmio_addr, ram_wdata, bus.mem2dc_data_in0, bus.mem2dc_data_in1);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      int d1;
      d1 = n_done1;
      bus.mem2dc_paddr0 = 30'h10; bus.mem2dc_write0 = 4'b0000; bus.mem2dc_valid0 = 1'b1;
      tick();
      total++;
      if ({ram_clken, ram_wren, arb_busy, bus.mem2dc_done0} !== 4'b1010) begin
         bad++; $display("FAIL rd_issue: clken/wren/busy/done0 got %b want 1010", {ram_clken, ram_wren, arb_busy, bus.mem2dc_done0});
      end
      total++;
      if (ram_addr !== 14'h10) begin bad++; $display("FAIL rd_addr: got %h want 0010", ram_addr); end
      tick();
      total++;
      if ({ram_clken, bus.mem2dc_done0} !== 2'b00) begin
         bad++; $display("FAIL rd_wait: clken/done0 got %b want 00", {ram_clken, bus.mem2dc_done0});
      end
      tick();
      total++;
      if (bus.mem2dc_done0 !== 1'b1 || bus.mem2dc_data_in0 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rd_done: done0=%b data=%h want 1 deadbeef", bus.mem2dc_done0, bus.mem2dc_data_in0);
      end
      bus.mem2dc_valid0 = 1'b0;
      tick();
      total++;
      if ({bus.mem2dc_done0, arb_busy} !== 2'b00) begin
         bad++; $display("FAIL rd_after: done0/busy got %b want 00", {bus.mem2dc_done0, arb_busy});
      end
      total++;
      if (n_done1 - d1 !== 0) begin bad++; $display("FAIL rd_done1: got %0d pulses want 0", n_done1 - d1); end
   endtask

   task automatic test_write_read();
      int w0;
      w0 = n_wren;
      mem[14'h20] = 32'hAAAAAAAA;
      bus.mem2dc_paddr1 = 30'h20; bus.mem2dc_write1 = 4'b0011;
      bus.mem2dc_data_out1 = 32'h12345678; bus.mem2dc_valid1 = 1'b1;
      tick();
      total++;
      if ({ram_wren, ram_clken, ram_byteen} !== 6'b110011 || ram_wdata !== 32'h12345678) begin
         bad++; $display("FAIL wr_issue: wren/clken/be=%b wdata=%h want 110011 12345678", {ram_wren, ram_clken, ram_byteen}, ram_wdata);
      end
      tick();
      total++;
      if (ram_wren !== 1'b0) begin bad++; $display("FAIL wr_wren_len: got %b want 0", ram_wren); end
      tick();
      total++;
      if ({bus.mem2dc_done1, bus.mem2dc_done0} !== 2'b10) begin
         bad++; $display("FAIL wr_done: done1/done0 got %b want 10", {bus.mem2dc_done1, bus.mem2dc_done0});
      end
      bus.mem2dc_valid1 = 1'b0;
      tick();
      bus.mem2dc_write1 = 4'b0000; bus.mem2dc_valid1 = 1'b1;
      tick(); tick(); tick();
      total++;
      if (bus.mem2dc_done1 !== 1'b1 || bus.mem2dc_data_in1 !== 32'hAAAA5678) begin
         bad++; $display("FAIL wr_readback: done1=%b data=%h want 1 aaaa5678", bus.mem2dc_done1, bus.mem2dc_data_in1);
      end
      bus.mem2dc_valid1 = 1'b0;
      tick();
      total++;
      if (n_wren - w0 !== 1) begin bad++; $display("FAIL wr_wren_cnt: got %0d want 1", n_wren - w0); end
   endtask

   task automatic test_simultaneous();
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      mem[14'h30] = 32'h30303030;
      mem[14'h40] = 32'h40404040;
      bus.mem2dc_paddr0 = 30'h30; bus.mem2dc_write0 = 4'b0000; bus.mem2dc_valid0 = 1'b1;
      bus.mem2dc_paddr1 = 30'h40; bus.mem2dc_write1 = 4'b0000; bus.mem2dc_valid1 = 1'b1;
      tick(); tick(); tick();
      total++;
      if ({bus.mem2dc_done1, bus.mem2dc_done0} !== 2'b01 || bus.mem2dc_data_in0 !== 32'h30303030) begin
         bad++; $display("FAIL sim_first: done1/done0=%b data=%h want 01 30303030", {bus.mem2dc_done1, bus.mem2dc_done0}, bus.mem2dc_data_in0);
      end
      bus.mem2dc_valid0 = 1'b0;
      tick();
      total++;
      if (ram_clken !== 1'b1 || ram_addr !== 14'h40) begin
         bad++; $display("FAIL sim_chain: clken=%b addr=%h want 1 0040", ram_clken, ram_addr);
      end
      tick();
      total++;
      if ({bus.mem2dc_done1, bus.mem2dc_done0} !== 2'b00) begin
         bad++; $display("FAIL sim_gap: got %b want 00", {bus.mem2dc_done1, bus.mem2dc_done0});
      end
      tick();
      total++;
      if ({bus.mem2dc_done1, bus.mem2dc_done0} !== 2'b10 || bus.mem2dc_data_in1 !== 32'h40404040) begin
         bad++; $display("FAIL sim_second: done1/done0=%b data=%h want 10 40404040", {bus.mem2dc_done1, bus.mem2dc_done0}, bus.mem2dc_data_in1);
      end
      bus.mem2dc_valid1 = 1'b0;
      tick();
   endtask

   task automatic test_fairness();
      int c0, c1, port;
      logic [1:0]  want;
      logic [31:0] want_d;
      c0 = n_done0; c1 = n_done1;
      mem[14'h50] = 32'h05050505;
      mem[14'h60] = 32'h06060606;
      bus.mem2dc_paddr0 = 30'h50; bus.mem2dc_valid0 = 1'b1;
      bus.mem2dc_paddr1 = 30'h60; bus.mem2dc_valid1 = 1'b1;
      for (int i = 1; i <= 36; i++) begin
         tick();
         port   = ((i / 3) - 1) % 2;
         want   = (i % 3 == 0) ? ((port == 0) ? 2'b01 : 2'b10) : 2'b00;
         want_d = (port == 0) ? 32'h05050505 : 32'h06060606;
         total++;
         if ({bus.mem2dc_done1, bus.mem2dc_done0} !== want || (want != 2'b00 && bus.mem2dc_data_in0 !== want_d)) begin
            bad++; $display("FAIL fair_cyc%0d: done1/done0=%b data=%h want %b %h", i, {bus.mem2dc_done1, bus.mem2dc_done0}, bus.mem2dc_data_in0, want, want_d);
         end
      end
      bus.mem2dc_valid0 = 1'b0; bus.mem2dc_valid1 = 1'b0;
      tick();
      total++;
      if (n_done0 - c0 !== 6 || n_done1 - c1 !== 6) begin
         bad++; $display("FAIL fair_count: done0=%0d done1=%0d want 6 6", n_done0 - c0, n_done1 - c1);
      end
   endtask

   task automatic test_mmio();
      int r0, k0;
      r0 = n_rden; k0 = n_clken;
      bus.mem2dc_paddr0 = 30'h2000_0100; bus.mem2dc_write0 = 4'b0000; bus.mem2dc_valid0 = 1'b1;
      tick();
      total++;
      if ({mmio_rden, mmio_wren, ram_clken} !== 6'b100000 || mmio_addr !== 29'h100) begin
         bad++; $display("FAIL mmio_issue: rden/wren/clken=%b addr=%h want 100000 100", {mmio_rden, mmio_wren, ram_clken}, mmio_addr);
      end
      for (int i = 2; i <= 4; i++) begin
         tick();
         total++;
         if (bus.mem2dc_done0 !== 1'b0) begin bad++; $display("FAIL mmio_early_n%0d: done0 got 1 want 0", i); end
      end
      tick();
      total++;
      if (bus.mem2dc_done0 !== 1'b1 || bus.mem2dc_data_in0 !== 32'hCAFE0001) begin
         bad++; $display("FAIL mmio_done: done0=%b data=%h want 1 cafe0001", bus.mem2dc_done0, bus.mem2dc_data_in0);
      end
      bus.mem2dc_valid0 = 1'b0;
      tick();
      total++;
      if (n_rden - r0 !== 1 || n_clken - k0 !== 0) begin
         bad++; $display("FAIL mmio_strobes: rden=%0d clken=%0d want 1 0", n_rden - r0, n_clken - k0);
      end
   endtask

   task automatic test_reset_mid_wait();
      int d0;
      mem[14'h70] = 32'h77777777;
      bus.mem2dc_paddr0 = 30'h70; bus.mem2dc_write0 = 4'b0000; bus.mem2dc_valid0 = 1'b1;
      tick(); tick();
      total++;
      if (arb_busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", arb_busy); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({arb_busy, bus.mem2dc_done0, ram_clken, mmio_rden} !== 4'b0000 || ram_addr !== 14'h0 || bus.mem2dc_data_in0 !== 32'h0) begin
         bad++; $display("FAIL rst_async: ctrl=%b addr=%h data=%h want 0000 0 0", {arb_busy, bus.mem2dc_done0, ram_clken, mmio_rden}, ram_addr, bus.mem2dc_data_in0);
      end
      bus.mem2dc_valid0 = 1'b0;
      tick();
      rst_n = 1'b1;
      d0 = n_done0;
      tick(); tick(); tick();
      total++;
      if (n_done0 - d0 !== 0 || arb_busy !== 1'b0) begin
         bad++; $display("FAIL rst_abort: done0 pulses=%0d busy=%b want 0 0", n_done0 - d0, arb_busy);
      end
      bus.mem2dc_paddr0 = 30'h10; bus.mem2dc_valid0 = 1'b1;
      tick(); tick(); tick();
      total++;
      if (bus.mem2dc_done0 !== 1'b1 || bus.mem2dc_data_in0 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rst_new_req: done0=%b data=%h want 1 deadbeef", bus.mem2dc_done0, bus.mem2dc_data_in0);
      end
      bus.mem2dc_valid0 = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_bus();
      mem[14'h10] = 32'hDEADBEEF;
      test_reset();
      test_single_read();
      test_write_read();
      test_simultaneous();
      test_fairness();
      test_mmio();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
